// File: rtl/scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : scan_pkg                                                    |
// | Brief  : Shared defaults and helpers for the digit scan multiplexer. |
// |          Holds default digit count, digit width, prescale and blank  |
// |          code, plus the slot-index width function.                   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package scan_pkg;

  localparam int         DEFAULT_NUM_DIGITS = 4;
  localparam int         DEFAULT_DIGIT_W    = 4;
  localparam int         DEFAULT_PRESCALE   = 100000;
  localparam logic [3:0] DEFAULT_BLANK_CODE = 4'hF;

  // Width of a slot index for n digits (n >= 2 gives at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : scan_counter                                                |
// | Brief  : Prescaler plus slot-index counter for display scanning.     |
// | Ports  : clk, rst      - clock / synchronous active-high reset       |
// |          enable_i      - run; low forces prescaler and index to 0    |
// |          tick_o        - prescaler at its last count (slot advance)  |
// |          wrap_o        - tick while on the last slot (frame end)     |
// |          idx_o         - current slot index                          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module scan_counter
  import scan_pkg::*;
#(
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int PRESCALE   = DEFAULT_PRESCALE,
  parameter int IDX_W      = idx_width(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  output logic             tick_o,
  output logic             wrap_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam int               CNT_W    = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick;

  always_comb begin
    tick  = enable_i && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!enable_i) begin
      // Disabling throws away the partial frame so re-enable starts clean.
      cnt_d = '0;
      idx_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign tick_o = tick;
  assign wrap_o = tick && (idx_q == IDX_LAST);
  assign idx_o  = idx_q;

endmodule
`default_nettype wire

// File: rtl/digit_scan_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : digit_scan_mux                                              |
// | Brief  : Time-multiplexed digit display driver with frame-aligned    |
// |          double buffering and leading-zero blanking.                 |
// | Ports  : clk, rst      - clock / synchronous active-high reset       |
// |          enable        - scan enable                                 |
// |          digits_in     - digit codes, digit 0 in the LSBs            |
// |          load          - capture digits_in (applied at frame wrap)   |
// |          blank_en      - leading-zero blanking                       |
// |          AN            - active-low anode enables (registered)       |
// |          AN_SEL        - current slot index (registered)             |
// |          digit_BCD     - code for the current slot (registered)      |
// |          frame_done    - one-cycle pulse after the last slot         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module digit_scan_mux
  import scan_pkg::*;
#(
  parameter int                 NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int                 DIGIT_W    = DEFAULT_DIGIT_W,
  parameter int                 PRESCALE   = DEFAULT_PRESCALE,
  parameter logic [DIGIT_W-1:0] BLANK_CODE = DIGIT_W'(DEFAULT_BLANK_CODE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]     digits_in,
  input  logic                              load,
  input  logic                              blank_en,
  output logic [NUM_DIGITS-1:0]             AN,
  output logic [idx_width(NUM_DIGITS)-1:0]  AN_SEL,
  output logic [DIGIT_W-1:0]                digit_BCD,
  output logic                              frame_done
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int BUS_W = NUM_DIGITS * DIGIT_W;

  logic [BUS_W-1:0]      pend_q, pend_d, act_q, act_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, blank;
  logic [IDX_W-1:0]      sel_q, sel_d, idx;
  logic [DIGIT_W-1:0]    bcd_q, bcd_d, cur_digit;
  logic                  fd_q, fd_d, cur_blank, zero_run;
  logic                  slot_tick, wrap;
  logic                  unused_slot_tick;

  scan_counter #(
    .NUM_DIGITS (NUM_DIGITS),
    .PRESCALE   (PRESCALE),
    .IDX_W      (IDX_W)
  ) u_scan_counter (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable),
    .tick_o   (slot_tick),
    .wrap_o   (wrap),
    .idx_o    (idx)
  );

  // Per-slot tick is not needed here; only frame wraps move data.
  assign unused_slot_tick = slot_tick;

  // Buffering: loads land in the pending buffer and are promoted only at a
  // frame wrap, so one frame never shows a mix of old and new digits. A load
  // on the wrap cycle itself goes straight to the active buffer.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    act_d      = act_q;
    if (load) begin
      pend_d     = digits_in;
      pend_vld_d = 1'b1;
    end
    if (wrap) begin
      if (load) begin
        act_d      = digits_in;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        act_d      = pend_q;
        pend_vld_d = 1'b0;
      end
    end
  end

  // Leading-zero mask: walk from the top digit down while everything seen
  // so far is zero. Digit 0 is always shown so a zero value stays visible.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_q[i*DIGIT_W +: DIGIT_W] == '0);
      blank[i] = blank_en && zero_run && (i != 0);
    end
  end

  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = act_q[i*DIGIT_W +: DIGIT_W];
        cur_blank = blank[i];
      end
    end
  end

  always_comb begin
    an_d  = '1;
    sel_d = idx;
    bcd_d = '0;
    fd_d  = wrap;
    if (!enable) begin
      // The counter index may still hold the old slot on this first
      // disabled edge, so the select is cleared explicitly.
      sel_d = '0;
    end else if (cur_blank) begin
      bcd_d = BLANK_CODE;
    end else begin
      an_d  = ~(NUM_DIGITS'(1) << idx);
      bcd_d = cur_digit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      act_q      <= '0;
      an_q       <= '1;
      sel_q      <= '0;
      bcd_q      <= '0;
      fd_q       <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      act_q      <= act_d;
      an_q       <= an_d;
      sel_q      <= sel_d;
      bcd_q      <= bcd_d;
      fd_q       <= fd_d;
    end
  end

  assign AN         = an_q;
  assign AN_SEL     = sel_q;
  assign digit_BCD  = bcd_q;
  assign frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_mux.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_digit_scan_mux                                           |
// | Brief  : Scoreboard bench for digit_scan_mux (4 digits, prescale 4). |
// |          Stimulus pushes per-cycle expected outputs into a queue;    |
// |          a monitor pops and compares on the falling edge.            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_digit_scan_mux;

  logic        clk = 1'b0;
  logic        rst, enable, load, blank_en;
  logic [15:0] digits_in;
  logic [3:0]  AN;
  logic [1:0]  AN_SEL;
  logic [3:0]  digit_BCD;
  logic        frame_done;

  typedef struct {
    int         cyc;
    string      tag;
    logic [3:0] an;
    logic [1:0] sel;
    logic [3:0] bcd;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  digit_scan_mux #(
    .NUM_DIGITS (4),
    .DIGIT_W    (4),
    .PRESCALE   (4),
    .BLANK_CODE (4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .digits_in  (digits_in),
    .load       (load),
    .blank_en   (blank_en),
    .AN         (AN),
    .AN_SEL     (AN_SEL),
    .digit_BCD  (digit_BCD),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_one(input int c, input string tag, input logic [3:0] an,
                          input logic [1:0] sel, input logic [3:0] bcd, input logic fd);
    exp_t e;
    e.cyc = c; e.tag = tag; e.an = an; e.sel = sel; e.bcd = bcd; e.fd = fd;
    sb.push_back(e);
  endtask

  // One slot lasts four cycles; frame_done rides on the last cycle of slot 3.
  task automatic push_slot(input int c, input string tag, input logic [1:0] sel,
                           input logic [3:0] an, input logic [3:0] bcd, input bit last);
    for (int k = 0; k < 4; k++)
      push_one(c + k, tag, an, sel, bcd, (last && k == 3));
  endtask

  // an4/bcd4 hold the four slots' expected values, slot 0 in the low nibble.
  task automatic push_frame(input int c, input string tag,
                            input logic [15:0] an4, input logic [15:0] bcd4);
    for (int s = 0; s < 4; s++)
      push_slot(c + 4*s, tag, 2'(s), an4[4*s +: 4], bcd4[4*s +: 4], (s == 3));
  endtask

  // Return just after the rising edge that brings cyc up to n.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every falling edge, compare against the entry due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_vec++;
        n_miss++;
        $display("FAIL %s cyc%0d: expectation skipped at cyc%0d", e.tag, e.cyc, cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_vec++;
        if (AN !== e.an || AN_SEL !== e.sel || digit_BCD !== e.bcd || frame_done !== e.fd) begin
          n_miss++;
          $display("FAIL %s cyc%0d: got AN=%b SEL=%0d BCD=%h FD=%b, expected AN=%b SEL=%0d BCD=%h FD=%b",
                   e.tag, cyc, AN, AN_SEL, digit_BCD, frame_done, e.an, e.sel, e.bcd, e.fd);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cyc%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset dominates a coincident enable and load.
    rst = 1'b1; enable = 1'b1; load = 1'b1; digits_in = 16'h5678; blank_en = 1'b0;
    push_one(1, "reset", 4'b1111, 2'd0, 4'h0, 1'b0);
    push_one(2, "reset", 4'b1111, 2'd0, 4'h0, 1'b0);
    wait_cyc(1);
    load = 1'b0;

    // Load 4,3,2,1: first frame still shows the reset zeros, then the data.
    wait_cyc(2);
    rst = 1'b0; load = 1'b1; digits_in = 16'h4321;
    push_frame(3,  "frameA_zero", 16'h7BDE, 16'h0000);
    push_frame(19, "frameB_4321", 16'h7BDE, 16'h4321);
    push_frame(35, "frameC_4321", 16'h7BDE, 16'h4321);
    wait_cyc(3);
    load = 1'b0;

    // Two loads mid-frame: old data holds to the wrap, the last load wins.
    wait_cyc(40);
    load = 1'b1; digits_in = 16'h8765;
    wait_cyc(41);
    digits_in = 16'h2468;
    push_frame(51, "frameD_2468", 16'h7BDE, 16'h2468);
    wait_cyc(42);
    load = 1'b0;

    // Load on the wrap cycle with blanking: 0007 shows only slot 0.
    wait_cyc(65);
    load = 1'b1; digits_in = 16'h0007; blank_en = 1'b1;
    push_frame(67, "frameE_0007", 16'hFFFE, 16'hFFF7);
    wait_cyc(66);
    load = 1'b0;

    // All-zero value keeps digit 0 lit.
    wait_cyc(70);
    load = 1'b1; digits_in = 16'h0000;
    push_frame(83, "frameF_0000", 16'hFFFE, 16'hFFF0);
    wait_cyc(71);
    load = 1'b0;

    // Interior zero below a nonzero digit stays lit.
    wait_cyc(85);
    load = 1'b1; digits_in = 16'h0305;
    push_frame(99, "frameG_0305", 16'hFBDE, 16'hF305);
    wait_cyc(86);
    load = 1'b0;

    // Drop enable in slot 2; load while disabled still goes to pending.
    wait_cyc(114);
    push_slot(115, "frameH_part", 2'd0, 4'b1110, 4'h5, 1'b0);
    push_slot(119, "frameH_part", 2'd1, 4'b1101, 4'h0, 1'b0);
    push_one(123, "frameH_part", 4'b1011, 2'd2, 4'h3, 1'b0);
    wait_cyc(123);
    enable = 1'b0;
    push_one(124, "disabled", 4'b1111, 2'd0, 4'h0, 1'b0);
    push_one(125, "disabled", 4'b1111, 2'd0, 4'h0, 1'b0);
    wait_cyc(124);
    load = 1'b1; digits_in = 16'h1111;
    wait_cyc(125);
    load = 1'b0; enable = 1'b1;
    push_frame(126, "frameI_reen", 16'hFBDE, 16'hF305);
    push_frame(142, "frameJ_1111", 16'h7BDE, 16'h1111);

    // Reset in slot 3 with pending data: pending is discarded.
    wait_cyc(157);
    push_slot(158, "frameK_part", 2'd0, 4'b1110, 4'h1, 1'b0);
    push_slot(162, "frameK_part", 2'd1, 4'b1101, 4'h1, 1'b0);
    push_slot(166, "frameK_part", 2'd2, 4'b1011, 4'h1, 1'b0);
    push_one(170, "frameK_part", 4'b0111, 2'd3, 4'h1, 1'b0);
    wait_cyc(160);
    load = 1'b1; digits_in = 16'h9999;
    wait_cyc(161);
    load = 1'b0;
    wait_cyc(170);
    rst = 1'b1;
    push_one(171, "rst_midframe", 4'b1111, 2'd0, 4'h0, 1'b0);
    wait_cyc(171);
    rst = 1'b0; blank_en = 1'b0;
    push_frame(172, "frameL_zero", 16'h7BDE, 16'h0000);
    push_frame(188, "frameM_zero", 16'h7BDE, 16'h0000);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 64 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
